// File: rtl/sap_core.sv
// sap_core: parametrised multi-cycle accumulator CPU with internal program/data
// RAM, carry/zero flags, conditional jumps and an external RAM load port.
module sap_core #(
  parameter int WIDTH         = 8,
  parameter int INSTR_SIZE    = 4,
  parameter int ADDRESS_WIDTH = WIDTH - INSTR_SIZE,
  parameter int LED_COUNT     = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_we,
  input  logic [ADDRESS_WIDTH-1:0] prog_addr,
  input  logic [WIDTH-1:0]         prog_data,
  output logic [LED_COUNT-1:0]     leds,
  output logic                     out_valid,
  output logic                     halted,
  output logic                     flag_c,
  output logic                     flag_z
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  localparam logic [INSTR_SIZE-1:0] OP_LDA = INSTR_SIZE'(4'b0001);
  localparam logic [INSTR_SIZE-1:0] OP_ADD = INSTR_SIZE'(4'b0010);
  localparam logic [INSTR_SIZE-1:0] OP_SUB = INSTR_SIZE'(4'b0011);
  localparam logic [INSTR_SIZE-1:0] OP_STA = INSTR_SIZE'(4'b0100);
  localparam logic [INSTR_SIZE-1:0] OP_LDI = INSTR_SIZE'(4'b0111);
  localparam logic [INSTR_SIZE-1:0] OP_JZ  = INSTR_SIZE'(4'b1000);
  localparam logic [INSTR_SIZE-1:0] OP_JMP = INSTR_SIZE'(4'b1100);
  localparam logic [INSTR_SIZE-1:0] OP_JC  = INSTR_SIZE'(4'b1101);
  localparam logic [INSTR_SIZE-1:0] OP_OUT = INSTR_SIZE'(4'b1110);
  localparam logic [INSTR_SIZE-1:0] OP_HLT = INSTR_SIZE'(4'b1111);

  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    T3 = 3'd2,
    T4 = 3'd3,
    T5 = 3'd4
  } stage_t;

  // SUB is A + ~B + 1, so carry-out set means no borrow
  function automatic logic [WIDTH:0] alu_calc(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             sub);
    logic [WIDTH-1:0] b_op;
    b_op = sub ? ~b : b;
    return {1'b0, a} + {1'b0, b_op} + (WIDTH+1)'(sub);
  endfunction

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

  logic [WIDTH-1:0]         mem_q [DEPTH];

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] mar_q, mar_d;
  logic [WIDTH-1:0]         ir_q, ir_d;
  logic [WIDTH-1:0]         a_q, a_d;
  logic [WIDTH-1:0]         b_q, b_d;
  logic                     c_q, c_d;
  logic                     z_q, z_d;
  stage_t                   stage_q, stage_d;
  logic [LED_COUNT-1:0]     leds_q, leds_d;
  logic                     out_valid_q, out_valid_d;
  logic                     halted_q, halted_d;

  logic                     core_we_s;
  logic                     mem_we_s;
  logic [ADDRESS_WIDTH-1:0] mem_addr_s;
  logic [WIDTH-1:0]         mem_wdata_s;
  logic [WIDTH-1:0]         rd_data_s;
  logic [INSTR_SIZE-1:0]    opcode_s;
  logic [ADDRESS_WIDTH-1:0] operand_s;
  logic [WIDTH:0]           alu_s;

  assign opcode_s  = ir_q[WIDTH-1 -: INSTR_SIZE];
  assign operand_s = ir_q[ADDRESS_WIDTH-1:0];
  assign rd_data_s = mem_q[mar_q];
  assign alu_s     = alu_calc(a_q, b_q, opcode_s == OP_SUB);

  // Next-state logic for the fetch/execute sequencer
  always_comb begin
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    z_d         = z_q;
    stage_d     = stage_q;
    leds_d      = leds_q;
    out_valid_d = 1'b0;
    halted_d    = halted_q;
    core_we_s   = 1'b0;
    if (!halted_q) begin
      case (stage_q)
        T1: begin
          mar_d   = pc_q;
          stage_d = T2;
        end
        T2: begin
          ir_d    = rd_data_s;
          pc_d    = pc_q + ADDRESS_WIDTH'(1);
          stage_d = T3;
        end
        T3: begin
          stage_d = T1;
          case (opcode_s)
            OP_LDI: a_d = WIDTH'(operand_s);
            OP_JMP: pc_d = operand_s;
            OP_JZ: begin
              if (z_q) begin
                pc_d = operand_s;
              end else begin
                pc_d = pc_q;
              end
            end
            OP_JC: begin
              if (c_q) begin
                pc_d = operand_s;
              end else begin
                pc_d = pc_q;
              end
            end
            OP_OUT: begin
              leds_d      = LED_COUNT'(a_q);
              out_valid_d = 1'b1;
            end
            OP_HLT: begin
              halted_d = 1'b1;
              stage_d  = T3;
            end
            OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
              mar_d   = operand_s;
              stage_d = T4;
            end
            default: stage_d = T1;
          endcase
        end
        T4: begin
          stage_d = T1;
          case (opcode_s)
            OP_LDA: a_d = rd_data_s;
            OP_STA: core_we_s = 1'b1;
            OP_ADD, OP_SUB: begin
              b_d     = rd_data_s;
              stage_d = T5;
            end
            default: stage_d = T1;
          endcase
        end
        T5: begin
          a_d     = alu_s[WIDTH-1:0];
          c_d     = alu_s[WIDTH];
          z_d     = is_zero(alu_s[WIDTH-1:0]);
          stage_d = T1;
        end
        default: stage_d = T1;
      endcase
    end else begin
      stage_d = stage_q;
    end
  end

  // Core state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= {ADDRESS_WIDTH{1'b0}};
      mar_q       <= {ADDRESS_WIDTH{1'b0}};
      ir_q        <= {WIDTH{1'b0}};
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      stage_q     <= T1;
      leds_q      <= {LED_COUNT{1'b0}};
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      z_q         <= z_d;
      stage_q     <= stage_d;
      leds_q      <= leds_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

  // RAM port ownership: loader while in reset or halted, core otherwise
  always_comb begin
    if (rst || halted_q) begin
      mem_we_s    = prog_we;
      mem_addr_s  = prog_addr;
      mem_wdata_s = prog_data;
    end else begin
      mem_we_s    = core_we_s;
      mem_addr_s  = mar_q;
      mem_wdata_s = a_q;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_addr_s] <= mem_wdata_s;
    end
  end

  assign leds      = leds_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign flag_c    = c_q;
  assign flag_z    = z_q;

endmodule

// File: tb/tb_sap_core.sv
// Directed testbench for sap_core: hand-assembled programs, expected LED values,
// flag states and cycle counts computed by hand.
module tb_sap_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [4:0] leds;
  logic       out_valid, halted, flag_c, flag_z;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc, halt_cyc, n_out, out_cyc, c_low, c_set_cyc;
  logic [4:0] first_led, last_led;

  always #5 clk = ~clk;

  sap_core #(.WIDTH(8), .INSTR_SIZE(4), .ADDRESS_WIDTH(4), .LED_COUNT(5)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .leds(leds), .out_valid(out_valid),
    .halted(halted), .flag_c(flag_c), .flag_z(flag_z)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic begin_reset(input string tag);
    rst = 1'b1;
    tick();
    check_eq(tag, {27'd0, leds, out_valid, halted, flag_c, flag_z}, 32'd0);
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 16; i++) load(4'(i), 8'hF0);
  endtask

  task automatic release_rst();
    rst       = 1'b0;
    cyc       = 0;
    halt_cyc  = 0;
    n_out     = 0;
    out_cyc   = 0;
    c_low     = 0;
    c_set_cyc = 0;
    first_led = 5'd0;
    last_led  = 5'd0;
  endtask

  task automatic run(input int budget, input string tag, input int exp_halt);
    while (!halted && cyc < budget) begin
      tick();
      cyc++;
      if (out_valid) begin
        if (n_out == 0) first_led = leds;
        last_led = leds;
        out_cyc  = cyc;
        n_out++;
      end
      if (cyc >= 8 && !flag_c) c_low++;
      if (flag_c && c_set_cyc == 0) c_set_cyc = cyc;
      if (halted) halt_cyc = cyc;
    end
    check_eq(tag, halt_cyc, exp_halt);
  endtask

  initial begin
    int changes;
    rst     = 1'b1;
    prog_we = 1'b0;
    prog_addr = 4'd0;
    prog_data = 8'd0;

    // Test 1: LDI 5, OUT, HLT and halt freeze
    begin_reset("t1_reset");
    clear_ram();
    load(4'd0, 8'h75); load(4'd1, 8'hE0); load(4'd2, 8'hF0);
    release_rst();
    run(60, "t1_halt_cycle", 9);
    check_eq("t1_out_cycle", out_cyc, 6);
    check_eq("t1_out_pulses", n_out, 1);
    check_eq("t1_leds", first_led, 5'd5);
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({leds, out_valid, halted, flag_c, flag_z} !== {5'd5, 1'b0, 1'b1, 1'b0, 1'b0}) changes++;
    end
    check_eq("t1_frozen", changes, 0);

    // Test 2: ADD wrap with carry, then JC taken
    begin_reset("t2_reset");
    clear_ram();
    load(4'd0, 8'h1E); load(4'd1, 8'h2F); load(4'd2, 8'hE0); load(4'd3, 8'hD6);
    load(4'd6, 8'h72); load(4'd7, 8'hE0);
    load(4'd14, 8'hF0); load(4'd15, 8'h20);
    release_rst();
    run(80, "t2_halt_cycle", 24);
    check_eq("t2_add_leds", first_led, 5'h10);
    check_eq("t2_carry_cycle", c_set_cyc, 9);
    check_eq("t2_jc_taken_out", n_out, 2);
    check_eq("t2_last_leds", last_led, 5'd2);
    check_eq("t2_flag_c", flag_c, 1'b1);
    check_eq("t2_flag_z", flag_z, 1'b0);

    // Test 3: SUB/JZ countdown loop
    begin_reset("t3_reset");
    clear_ram();
    load(4'd0, 8'h73); load(4'd1, 8'h3F); load(4'd2, 8'h85); load(4'd3, 8'hC1);
    load(4'd5, 8'hE0); load(4'd15, 8'h01);
    release_rst();
    run(200, "t3_halt_cycle", 39);
    check_eq("t3_out_cycle", out_cyc, 36);
    check_eq("t3_exit_once", n_out, 1);
    check_eq("t3_leds", last_led, 5'd0);
    check_eq("t3_flag_z", flag_z, 1'b1);
    check_eq("t3_carry_held", c_low, 0);

    // Test 4: STA then LDA of the same address, RAM survives reset
    begin_reset("t4_reset");
    clear_ram();
    load(4'd0, 8'h79); load(4'd1, 8'h4D); load(4'd2, 8'h70); load(4'd3, 8'h1D);
    load(4'd4, 8'hE0); load(4'd13, 8'h00);
    release_rst();
    run(80, "t4_halt_cycle", 20);
    check_eq("t4_out_cycle", out_cyc, 17);
    check_eq("t4_leds", last_led, 5'd9);
    begin_reset("t4b_reset");
    load(4'd0, 8'h1D); load(4'd1, 8'hE0); load(4'd2, 8'hF0);
    release_rst();
    run(60, "t4b_halt_cycle", 10);
    check_eq("t4b_ram13", last_led, 5'd9);

    // Test 5: reset coinciding with the STA write edge
    begin_reset("t5_reset");
    clear_ram();
    load(4'd0, 8'h77); load(4'd1, 8'hE0); load(4'd2, 8'h4C); load(4'd12, 8'h55);
    release_rst();
    for (int i = 0; i < 9; i++) tick();
    check_eq("t5_leds_before", leds, 5'd7);
    begin_reset("t5_abort_outputs");
    load(4'd0, 8'h1C); load(4'd1, 8'hE0); load(4'd2, 8'hF0);
    release_rst();
    run(60, "t5b_halt_cycle", 10);
    check_eq("t5_ram12_kept", last_led, 5'h15);

    // Test 6: load port gated while running, honoured while halted
    begin_reset("t6_reset");
    clear_ram();
    load(4'd0, 8'h71); load(4'd1, 8'hE0); load(4'd2, 8'hF0); load(4'd10, 8'h33);
    release_rst();
    prog_we = 1'b1; prog_addr = 4'd10; prog_data = 8'hAA;
    tick();
    cyc++;
    prog_we = 1'b0;
    run(60, "t6_halt_cycle", 9);
    check_eq("t6_leds", last_led, 5'd1);
    load(4'd0, 8'h1A); load(4'd1, 8'hE0); load(4'd2, 8'hF0);
    begin_reset("t6b_reset");
    release_rst();
    run(60, "t6b_halt_cycle", 10);
    check_eq("t6_running_write_ignored", last_led, 5'h13);
    load(4'd10, 8'h44);
    begin_reset("t6c_reset");
    release_rst();
    run(60, "t6c_halt_cycle", 10);
    check_eq("t6_halted_write_taken", last_led, 5'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sap_core.md
# sap_core

Parametrised successor to the 8-bit bus-sequenced CPU. It is a single-clock, fully synchronous multi-cycle core with internal program/data RAM and a generalised word and address width. The instruction set adds SUB, STA, conditional jumps and carry/zero flags, and the core supports program loading from outside through a RAM load port. It sits at the top of the board design, driving the LED output register and taking its program from a loader or testbench.

## Interface
- WIDTH, 8: data word and instruction width.
- INSTR_SIZE, 4: opcode field width (upper bits of instruction).
- ADDRESS_WIDTH, WIDTH-INSTR_SIZE: operand/address field width; RAM depth = 2^ADDRESS_WIDTH.
- LED_COUNT, 5: output register width. A[LED_COUNT-1:0] is output; zero-extended if LED_COUNT > WIDTH.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- prog_we  in  1  RAM load write enable (honoured only while rst=1 or halted=1).
- prog_addr  in  ADDRESS_WIDTH  RAM load address.
- prog_data  in  WIDTH  RAM load data.
- leds  out  LED_COUNT  output register.
- out_valid  out  1  one-cycle pulse when leds updated by OUT.
- halted  out  1  high from the HLT execute edge until reset.
- flag_c, flag_z  out  1 each  carry and zero flags.

## Operation
- Registers: PC (ADDRESS_WIDTH), MAR (ADDRESS_WIDTH), IR (WIDTH), A, B (WIDTH), C, Z, stage (T1..T5), out_reg, halted.
- Opcodes:
  - 0000 NOP.
  - 0001 LDA: A<=RAM[op].
  - 0010 ADD: A<=A+RAM[op].
  - 0011 SUB: A<=A-RAM[op].
  - 0100 STA: RAM[op]<=A.
  - 0111 LDI: A<=zero-extended op.
  - 1000 JZ: PC<=op if Z.
  - 1100 JMP: PC<=op.
  - 1101 JC: PC<=op if C.
  - 1110 OUT.
  - 1111 HLT.
  - All other codes execute as NOP.
- Stages:
  - T1: MAR<=PC.
  - T2: IR<=RAM[MAR]; PC<=PC+1, wrapping 2^ADDRESS_WIDTH-1 -> 0.
  - T3: execute.
    - NOP, LDI, JMP, JC, JZ, OUT -> T1.
    - HLT sets halted; stage holds.
    - LDA, STA, ADD, SUB: MAR<=op -> T4.
  - T4:
    - LDA: A<=RAM[MAR] -> T1.
    - STA: RAM[MAR]<=A -> T1.
    - ADD/SUB: B<=RAM[MAR] -> T5.
  - T5: ADD/SUB: A<=result; C, Z updated -> T1.
- Arithmetic:
  - WIDTH+1-bit result; A takes the low WIDTH bits (wrap-around).
  - ADD: C = bit WIDTH of A+B.
  - SUB: computed as A+~B+1; C=1 means no borrow (A>=B).
  - Z = (low WIDTH bits == 0).
  - Only ADD and SUB modify flags.
- RAM: single-port, synchronous write, combinational read, WIDTH x 2^ADDRESS_WIDTH. Not cleared by reset.
- Load port: prog_we writes RAM[prog_addr]<=prog_data on the clock edge when rst=1 or halted=1. It is ignored while running. No core RAM access occurs in those states.

## Timing
- Reset values:
  - PC, MAR, IR, A, B, C, Z = 0.
  - stage = T1, leds = 0, out_valid = 0, halted = 0.
- First T1 executes on the first rising edge with rst=0.
- Latency in cycles, fetch included:
  - 3 cycles: NOP, LDI, JMP, JC, JZ (taken or not), OUT, HLT.
  - 4 cycles: LDA, STA.
  - 5 cycles: ADD, SUB.
- OUT: leds updated at the T3 edge. out_valid is high for exactly the following cycle.
- Branch target is fetched in the next T1, so there are no delay slots.
- STA followed by LDA of the same address returns the stored value.
- Reset mid-instruction:
  - Aborts immediately; all registers take reset values.
  - An STA write coinciding with the rst edge is suppressed.
- Halted: all registers frozen, with leds held and flags held. Only rst clears halted.
- Instruction fetched from address 2^ADDRESS_WIDTH-1: PC wraps to 0.

## Test plan
- Load program [0]=LDI 5,[1]=OUT,[2]=HLT -> leds=5 with out_valid pulse at cycle 6 after rst release; halted=1 at cycle 9; state frozen for 20 further cycles.
- ADD wrap: RAM[14]=0xF0, RAM[15]=0x20, program LDA 14, ADD 15, OUT, HLT -> A=0x10, C=1, Z=0, leds=0x10; ADD takes exactly 5 cycles.
- SUB/JZ loop: A=3, RAM[15]=1, loop SUB 15; JZ exit; JMP loop -> Z=1 after third SUB, C=1 throughout, exit taken once; leds=0 at exit OUT.
- STA/LDA: LDI 9, STA 13, LDI 0, LDA 13, OUT -> leds=9; RAM[13]=9 readable via final state.
- Reset mid-STA: assert rst on the T4 edge of STA 12 (RAM[12]=0x55 preloaded, A=7) -> RAM[12] remains 0x55; all outputs zero next cycle.
- Load port gating: prog_we pulse while running -> RAM unchanged. Same pulse while halted -> RAM written, and the new program runs after rst.
